// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle accumulator CPU: opcodes, FSM states, size defaults.
package proc_pkg;
  localparam int DEFAULT_DW        = 16;
  localparam int DEFAULT_MEM_WORDS = 64;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1110;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    ALU,
    WB,
    HALTED
  } state_t;
endpackage

// File: rtl/proc_regfile.sv
// Eight-entry register file: one write port, two combinational read ports, async active-low clear.
module proc_regfile
  import proc_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          we,
  input  logic [2:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [2:0]    raddr_a,
  input  logic [2:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);
  logic [7:0][DW-1:0] regs;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)  regs <= '0;
    else if (we)  regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/processor.sv
// Multi-cycle accumulator CPU: every datapath move goes through one shared bus,
// which is also exported so the enclosing system can watch execution.
module processor
  import proc_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [MEM_WORDS*DW-1:0] mem,
  output logic [DW-1:0]           bus
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [MEM_WORDS-1:0][DW-1:0] mem_arr;
  state_t                       state;
  logic [AW-1:0]                pc;
  logic [DW-1:0]                ir, a, g;
  logic [3:0]                   op;
  logic [2:0]                   rx, ry;
  logic [DW-1:0]                imm, rd_x, rd_y;
  logic                         rf_we;

  assign mem_arr = mem;
  assign op      = ir[15:12];
  assign rx      = ir[11:9];
  assign ry      = ir[8:6];
  assign imm     = {{(DW-9){1'b0}}, ir[8:0]};

  // Register writes always take their data from the bus, so reads of rY/rX
  // precede the write within the same cycle and rX = rY behaves naturally.
  proc_regfile #(.DW(DW)) u_rf (
    .clock   (clock),
    .resetn  (resetn),
    .we      (rf_we),
    .waddr   (rx),
    .wdata   (bus),
    .raddr_a (rx),
    .raddr_b (ry),
    .rdata_a (rd_x),
    .rdata_b (rd_y)
  );

  always_comb begin
    bus   = '0;
    rf_we = 1'b0;
    if (resetn) begin
      unique case (state)
        FETCH: bus = mem_arr[pc];
        EXEC: begin
          unique case (op)
            OP_MV:          begin bus = rd_y;                 rf_we = 1'b1; end
            OP_MVI:         begin bus = imm;                  rf_we = 1'b1; end
            OP_LD:          begin bus = mem_arr[rd_y[AW-1:0]]; rf_we = 1'b1; end
            OP_ADD, OP_SUB: bus = rd_x;
            default:        bus = '0;
          endcase
        end
        ALU:     bus = rd_y;
        WB:      begin bus = g; rf_we = 1'b1; end
        default: bus = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      a     <= '0;
      g     <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          ir    <= bus;
          pc    <= pc + 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          if (op == OP_ADD || op == OP_SUB) begin
            a     <= bus;
            state <= ALU;
          end else if (op == OP_HALT) begin
            state <= HALTED;
          end else begin
            state <= FETCH;
          end
        end
        ALU: begin
          g     <= (op == OP_SUB) ? a - bus : a + bus;
          state <= WB;
        end
        WB:      state <= FETCH;
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_processor.sv
// Bench for processor: an instruction-level reference model predicts the bus value of every cycle.
module tb_processor;
  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic [63:0][15:0]   mem_img;
  logic [1023:0]       mem;
  logic [15:0]         bus;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  bit          care_q[$];

  assign mem = mem_img;

  processor #(.DW(16), .MEM_WORDS(64)) dut (
    .clock  (clock),
    .resetn (resetn),
    .mem    (mem),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Interpret the program one instruction at a time, listing the bus value each cycle shows.
  function automatic void build_expected(input int n);
    logic [15:0] r[8];
    logic [15:0] ir, v;
    logic [3:0]  op;
    int          pc, x, y;
    bit          halted;
    pc = 0;
    halted = 0;
    for (int k = 0; k < 8; k++) r[k] = 16'h0;
    exp_q.delete();
    care_q.delete();
    while (exp_q.size() < n) begin
      if (halted) begin
        exp_q.push_back(16'h0); care_q.push_back(1);
        continue;
      end
      ir = mem_img[pc];
      exp_q.push_back(ir); care_q.push_back(1);
      pc = (pc + 1) % 64;
      op = ir[15:12];
      x  = int'(ir[11:9]);
      y  = int'(ir[8:6]);
      case (op)
        4'h0: begin v = r[y]; exp_q.push_back(v); care_q.push_back(1); r[x] = v; end
        4'hA: begin v = {7'b0, ir[8:0]}; exp_q.push_back(v); care_q.push_back(1); r[x] = v; end
        4'h8: begin v = mem_img[r[y] % 64]; exp_q.push_back(v); care_q.push_back(1); r[x] = v; end
        4'h2, 4'h3: begin
          v = (op == 4'h2) ? r[x] + r[y] : r[x] - r[y];
          exp_q.push_back(r[x]); care_q.push_back(1);
          exp_q.push_back(r[y]); care_q.push_back(1);
          exp_q.push_back(v);    care_q.push_back(1);
          r[x] = v;
        end
        4'hE: begin exp_q.push_back(16'h0); care_q.push_back(0); halted = 1; end
        default: begin exp_q.push_back(16'h0); care_q.push_back(1); end
      endcase
    end
  endfunction

  function automatic void put_dump(input int base);
    for (int k = 0; k < 8; k++) mem_img[base+k] = 16'((k << 9) | (k << 6));
  endfunction

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    mem_img = '0;
    mem_img[0] = 16'hA022;
    resetn = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (bus !== 16'h0) begin
        errors++; $display("FAIL reset_bus: bus=%h expected 0000", bus);
      end
    end
    @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (bus !== 16'hA022) begin
      errors++; $display("FAIL reset_first_fetch: bus=%h expected a022", bus);
    end
  endtask

  task automatic test_mvi_mv();
    mem_img = '0;
    mem_img[0] = 16'hA022;
    mem_img[1] = 16'h0440;
    mem_img[2] = 16'hE000;
    apply_reset();
    build_expected(14);
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      if (care_q[i]) begin
        checks++;
        if (bus !== exp_q[i]) begin
          errors++; $display("FAIL mvi_mv cycle %0d: bus=%h expected %h", i, bus, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_add();
    mem_img = '0;
    mem_img[0] = 16'hA022;
    mem_img[1] = 16'hA83E;
    mem_img[2] = 16'h2100;
    put_dump(3);
    mem_img[11] = 16'hE000;
    apply_reset();
    build_expected(32);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (care_q[i]) begin
        checks++;
        if (bus !== exp_q[i]) begin
          errors++; $display("FAIL add cycle %0d: bus=%h expected %h", i, bus, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_sub_wrap();
    mem_img = '0;
    mem_img[0] = 16'hA201;
    mem_img[1] = 16'hA402;
    mem_img[2] = 16'h3280;
    put_dump(3);
    mem_img[11] = 16'hE000;
    apply_reset();
    build_expected(32);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      if (care_q[i]) begin
        checks++;
        if (bus !== exp_q[i]) begin
          errors++; $display("FAIL sub_wrap cycle %0d: bus=%h expected %h", i, bus, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ld();
    mem_img = '0;
    mem_img[0] = 16'hA60A;
    mem_img[1] = 16'h8AC0;
    put_dump(2);
    mem_img[10] = 16'hBEEF;
    mem_img[11] = 16'hE000;
    apply_reset();
    build_expected(34);
    for (int i = 0; i < 34; i++) begin
      @(negedge clock);
      if (care_q[i]) begin
        checks++;
        if (bus !== exp_q[i]) begin
          errors++; $display("FAIL ld cycle %0d: bus=%h expected %h", i, bus, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_add();
    mem_img = '0;
    mem_img[0] = 16'hA022;
    mem_img[1] = 16'hA83E;
    mem_img[2] = 16'h2100;
    mem_img[3] = 16'hE000;
    apply_reset();
    build_expected(7);
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++;
      if (bus !== exp_q[i]) begin
        errors++; $display("FAIL mid_add_pre cycle %0d: bus=%h expected %h", i, bus, exp_q[i]);
      end
    end
    // Now in the ALU cycle of ADD R0,R4: abort it asynchronously.
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (bus !== 16'h0) begin
      errors++; $display("FAIL mid_add_async_bus: bus=%h expected 0000", bus);
    end
    mem_img = '0;
    put_dump(0);
    mem_img[8] = 16'hE000;
    apply_reset();
    build_expected(20);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (care_q[i]) begin
        checks++;
        if (bus !== exp_q[i]) begin
          errors++; $display("FAIL mid_add_post cycle %0d: bus=%h expected %h", i, bus, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ops[7];
    logic [3:0] op;
    ops = '{4'h0, 4'hA, 4'h2, 4'h3, 4'h8, 4'hE, 4'h5};
    for (int it = 0; it < 5; it++) begin
      for (int w = 0; w < 64; w++) begin
        op = ops[$urandom_range(it < 3 ? 4 : 6, 0)];
        if ($urandom_range(3, 0) == 0) mem_img[w] = 16'($urandom);
        else mem_img[w] = {op, 12'($urandom)};
      end
      apply_reset();
      build_expected(400);
      for (int i = 0; i < 400; i++) begin
        @(negedge clock);
        if (care_q[i]) begin
          checks++;
          if (bus !== exp_q[i]) begin
            errors++; $display("FAIL random it%0d cycle %0d: bus=%h expected %h", it, i, bus, exp_q[i]);
          end
        end
      end
    end
  endtask

  initial begin
    mem_img = '0;
    test_reset();
    test_mvi_mv();
    test_add();
    test_sub_wrap();
    test_ld();
    test_reset_mid_add();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/processor.md
Name: processor

Overview:
- Small multi-cycle 16-bit accumulator-style CPU with eight 16-bit registers R0..R7.
- It fetches instructions from a read-only 64-word program memory supplied as a flat input port.
- It executes them over a shared internal 16-bit bus, which it exports for observation.
- It is the top compute block of the lab design; the memory image is driven by the enclosing system or bench.

Parameters:
- DW, 16, data/instruction width.
- MEM_WORDS, 64, number of program-memory words; address width is 6.

Ports:
- clock  input  1  single system clock; rising-edge active.
- resetn  input  1  asynchronous, active-low reset.
- mem  input  MEM_WORDS*DW (64x16 packed, word i at bits [16i+15:16i])  program/data memory image, read-only.
- bus  output  16  current value driven on the internal datapath bus.

Behaviour:
- Reset: the block has one clock; reset is asynchronous and active-low. While resetn=0:
  - R0..R7, IR, A and G are 0.
  - PC is 0.
  - State is FETCH.
  - bus reads 0.
- Reset asserted mid-instruction aborts the instruction immediately; no partial register write occurs.
- PC is a separate 6-bit register. It wraps from 63 to 0.
- Instruction format: op=IR[15:12], rX=IR[11:9], rY=IR[8:6], imm9=IR[8:0] (zero-extended to 16).
- Opcodes:
  - 0000 MV: rX <= rY.
  - 1010 MVI: rX <= imm9.
  - 0010 ADD: rX <= rX + rY, mod 2^16, carry discarded.
  - 0011 SUB: rX <= rX - rY, mod 2^16, borrow discarded.
  - 1000 LD: rX <= mem[rY[5:0]].
  - 1110 HALT.
  - All other opcodes execute as a 1-cycle NOP after fetch.
- State machine, one state per clock:
  - FETCH: bus = mem[PC]; IR <= bus; PC <= PC+1; go to EXEC.
  - EXEC, MV: bus = rY; rX <= bus; go to FETCH.
  - EXEC, MVI: bus = imm9; rX <= bus; go to FETCH.
  - EXEC, LD: bus = mem[rY[5:0]]; rX <= bus; go to FETCH.
  - EXEC, ADD/SUB: bus = rX; A <= bus; go to ALU.
  - ALU: bus = rY; G <= A ± bus; go to WB.
  - WB: bus = G; rX <= bus; go to FETCH.
  - EXEC, HALT: go to HALTED. In HALTED, bus = 0 and no state changes until reset.
  - EXEC, NOP: bus = 0; go to FETCH.
- Latency: MV/MVI/LD/NOP take 2 cycles; ADD/SUB take 4 cycles.
- Source/destination overlap: when rX = rY, the source value is read before the write. Example: ADD R1,R1 doubles R1.
- bus is a combinational mux of the current state and datapath. Exactly one source drives it each cycle.
- mem is sampled combinationally; a change to mem takes effect at the next read.

Decomposition:
- Shared package proc_pkg holds:
  - the opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_LD, OP_HALT);
  - the state enum (FETCH, EXEC, ALU, WB, HALTED);
  - the DW/MEM_WORDS defaults.
- One natural sub-module, proc_regfile: 8x16 registers, one write port, two combinational read ports, async active-low clear.
- Control FSM, ALU and bus mux stay in processor.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> bus=0, PC=0, all registers 0; release -> first FETCH puts mem[0] on bus.
- MVI then MV:
  - Program: mem[0]=0xA022 (MVI R0,#34), mem[1]=0x0440 (MV R2,R1), mem[2]=0xE000 (HALT).
  - Required: R0=34 after 2 cycles; R2=R1 after 4 cycles; bus=0 and halted from cycle 6 on.
- ADD: MVI R0,#34; MVI R4,#62; ADD R0,R4 (0x2100) -> R0=96 four cycles after ADD is fetched. bus sequence during ADD is 0x2100, 34, 62, 96.
- SUB wrap: MVI R1,#1; MVI R2,#2; SUB R1,R2 (0x3280) -> R1=0xFFFF; no other register changes.
- LD: mem[10]=0xBEEF; MVI R3,#10; LD R5,R3 (0x8AC0) -> R5=0xBEEF; bus=0xBEEF during LD execute.
- Reset mid-ADD: assert resetn=0 during the ALU state -> destination register cleared to 0 asynchronously, no write of G; after release, execution restarts at mem[0].
